instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//  PC register, instruction-memory request handshake and IF/ID pipeline register.
//  Sits directly upstream of controlUnit. if_id_opcode (instr[31:26]) drives its Opcode input.
//  Takes branch/jump redirects from later stages and flushes the IF/ID slot on redirect.
//  Detects a hung instruction memory with a bounded wait counter.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//  WAIT_TIMEOUT  8              cycles imem_req may stay high without imem_ready before fetch_err
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous, active-low reset
//  stall           in   1   hazard hold from ID: freeze PC and IF/ID
//  redirect_valid  in   1   taken branch or jump this cycle
//  redirect_pc     in   32  redirect target; bits [1:0] ignored and forced to 00
//  imem_req        out  1   fetch request to instruction memory
//  imem_addr       out  32  fetch address, equal to pc
//  imem_rdata      in   32  instruction word; valid when imem_ready=1
//  imem_ready      in   1   response strobe; may be high in the same cycle as imem_req
//  pc              out  32  current fetch PC
//  if_id_valid     out  1   IF/ID holds a real instruction
//  if_id_instr     out  32  IF/ID instruction; 32'h0 (NOP) when not valid
//  if_id_opcode    out  6   if_id_instr[31:26], to controlUnit.Opcode
//  if_id_pc_plus4  out  32  PC+4 of the IF/ID instruction
//  fetch_err       out  1   sticky: imem timeout occurred
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC; if_id_valid=0; if_id_instr=0; if_id_pc_plus4=0; fetch_err=0.
//   - Wait counter=0; state=S_BOOT; imem_req=0.
//  FSM:
//   - S_BOOT: one idle cycle after reset release, then S_FETCH.
//   - S_FETCH: imem_req = !stall && !redirect_valid.
//   - S_ERR: imem_req=0 and if_id_valid=0. Left only by reset.
//  Accept = imem_req && imem_ready. On the accepting edge:
//   - if_id_instr<=imem_rdata; if_id_valid<=1; if_id_pc_plus4<=pc+4; pc<=pc+4.
//   - Zero-wait memory therefore gives one instruction per cycle.
//   - Instruction is visible in IF/ID one cycle after the accepting edge.
//  No accept, not stalled, no redirect:
//   - if_id_valid<=0 and if_id_instr<=0 (bubble). pc holds.
//  stall=1 (no redirect):
//   - pc and the whole IF/ID register hold, including if_id_valid.
//   - imem_req=0; any imem_ready is ignored.
//  redirect_valid=1 (highest priority, overrides stall and accept):
//   - pc<={redirect_pc[31:2],2'b00}; if_id_valid<=0; if_id_instr<=0.
//   - Wait counter<=0; imem_rdata is discarded.
//  Arithmetic: pc+4 is mod 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
//  Wait counter (saturating, width = clog2(WAIT_TIMEOUT+1)):
//   - Increments each cycle imem_req=1 && imem_ready=0.
//   - Clears on accept, stall or redirect.
//   - On reaching WAIT_TIMEOUT: fetch_err<=1, enter S_ERR.
//  Simultaneous stall+redirect: the redirect wins. Simultaneous accept+redirect: the data is dropped.
//  Reset mid-request: everything returns to reset values immediately; the pending response is ignored.
// TESTING
//  1. Reset release with RESET_PC=0 and zero-wait memory returning addr-tagged words
//     -> imem_addr 0,4,8,... one per cycle.
//     -> if_id_pc_plus4 4,8,12 with if_id_valid=1 from the 3rd cycle.
//  2. stall=1 for 3 cycles holding instr 0x8C010004 (lw)
//     -> IF/ID, if_id_opcode=6'b100011 and pc unchanged; imem_req=0.
//     -> Flow resumes in order.
//  3. redirect_valid=1, redirect_pc=0x00000043, with stall=1 the same cycle
//     -> pc=0x40; next cycle if_id_valid=0, if_id_instr=0.
//     -> Then 0x40,0x44 fetched.
//  4. pc=0xFFFFFFFC, accept -> pc=0x00000000; if_id_pc_plus4=0x00000000.
//  5. imem_ready held 0 with WAIT_TIMEOUT=8
//     -> fetch_err=1 after the 8th waiting cycle; imem_req=0 and stays 0.
//     -> Only rst_n clears the error.
//  6. rst_n pulsed low while imem_req=1 and a response is pending
//     -> outputs at reset values asynchronously.
//     -> Late imem_ready is not captured.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, imem request handshake, IF/ID pipeline
// register and a bounded wait counter that latches a sticky fetch error.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [5:0]  if_id_opcode,
  output logic [31:0] if_id_pc_plus4,
  output logic        fetch_err
);

  localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc4_q, pc4_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          accept;
  logic [31:0]   pc_plus4;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    err_d    = err_q;
    wait_d   = wait_q;
    imem_req = 1'b0;
    pc_plus4 = pc_q + 32'd4;

    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: imem_req = !stall && !redirect_valid;
      S_ERR:   imem_req = 1'b0;
      default: state_d = S_BOOT;
    endcase

    accept = imem_req && imem_ready;

    // Priority: redirect > stall > accept > bubble
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      instr_d = '0;
      wait_d  = '0;
    end else if (stall) begin
      wait_d = '0;
    end else if (accept) begin
      instr_d = imem_rdata;
      valid_d = 1'b1;
      pc4_d   = pc_plus4;
      pc_d    = pc_plus4;
      wait_d  = '0;
    end else begin
      valid_d = 1'b0;
      instr_d = '0;
      if (imem_req) begin
        if (wait_q != TIMEOUT_C) begin
          wait_d = wait_q + 1'b1;
        end
        if (wait_d == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
    end

    // The error state keeps the IF/ID slot empty even under stall
    if (state_q == S_ERR) begin
      valid_d = 1'b0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_opcode   = instr_q[31:26];
  assign if_id_pc_plus4 = pc4_q;
  assign fetch_err      = err_q;

endmodule
